// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared SPI definitions: controller state encoding and the
//               default word width / clock divide used by master and slave.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int SPI_DATA_W  = 8;
    localparam int SPI_CLK_DIV = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        XFER  = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } spi_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_clk_div.sv
`default_nettype none
// ============================================================================
// Module      : spi_clk_div
// Description : Half-period timer for the SPI master. Counts CLK_DIV enabled
//               cycles and flags the last one with a single-cycle half_tick.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_en,
    input  logic i_clear,
    output logic o_half_tick
);

    localparam int                DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]  C_DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] r_cnt;

    // Free-running modulo-CLK_DIV count while enabled; restarts on every accept.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == C_DIV_LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_half_tick = i_en && (r_cnt == C_DIV_LAST);

endmodule
`default_nettype wire

// File: rtl/spi_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_ctrl
// Description : SPI mode-0 master, MSB first, one DATA_W-bit word per cs
//               frame. Valid/ready word interface on the system side.
//               Optional macro SPI_MASTER_CTRL_BURST_EN: a word offered at
//               the end of HOLD is chained into the same cs frame.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_W  = SPI_DATA_W,
    parameter int CLK_DIV = SPI_CLK_DIV
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [DATA_W-1:0] i_tx_data,
    input  logic              i_tx_valid,
    output logic              o_tx_ready,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_rx_valid,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic              cs
);

    localparam int                BIT_W      = $clog2(DATA_W) + 1;
    localparam int                DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BIT_W-1:0]  C_BITS     = BIT_W'(DATA_W);
    localparam logic [DIV_W-1:0]  C_DIV_LAST = DIV_W'(CLK_DIV - 1);

    spi_state_t        r_state;
    logic [DATA_W-1:0] r_tx_sr;
    logic [DATA_W-1:0] r_rx_sr;
    logic [DATA_W-1:0] r_rx_data;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic [DIV_W-1:0]  r_gap_cnt;
    logic              r_sclk;
    logic              r_cs;
    logic              r_mosi;
    logic              r_rx_valid;

    logic              w_half_tick;
    logic              w_div_en;
    logic              w_accept;

    // The bit timer only runs while the frame is active; GAP is timed locally.
    assign w_div_en = (r_state == SETUP) || (r_state == XFER) || (r_state == HOLD);

`ifdef SPI_MASTER_CTRL_BURST_EN
    // Ready also opens for the single cycle that closes HOLD, so a waiting
    // word can be chained without releasing cs.
    assign o_tx_ready = (r_state == IDLE) || ((r_state == HOLD) && w_half_tick);
`else
    assign o_tx_ready = (r_state == IDLE);
`endif

    assign w_accept = i_tx_valid && o_tx_ready;

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_en        (w_div_en),
        .i_clear     (w_accept),
        .o_half_tick (w_half_tick)
    );

    // Frame sequencer: drives cs/sclk/mosi and both shift registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_tx_sr    <= '0;
            r_rx_sr    <= '0;
            r_rx_data  <= '0;
            r_bit_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_sclk     <= 1'b0;
            r_cs       <= 1'b1;
            r_mosi     <= 1'b0;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_tx_sr   <= i_tx_data;
                        r_bit_cnt <= '0;
                        r_cs      <= 1'b0;
                        r_mosi    <= i_tx_data[DATA_W-1];
                        r_state   <= SETUP;
                    end
                end
                SETUP: begin
                    // The first rising edge opens XFER; miso is sampled on it.
                    if (w_half_tick) begin
                        r_sclk    <= 1'b1;
                        r_rx_sr   <= {r_rx_sr[DATA_W-2:0], miso};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        r_state   <= XFER;
                    end
                end
                XFER: begin
                    if (w_half_tick) begin
                        if (r_sclk) begin
                            // Falling edge: advance mosi unless this was the last bit.
                            r_sclk <= 1'b0;
                            if (r_bit_cnt != C_BITS) begin
                                r_tx_sr <= r_tx_sr << 1;
                                r_mosi  <= r_tx_sr[DATA_W-2];
                            end
                        end else if (r_bit_cnt == C_BITS) begin
                            // Final low half-period complete.
                            r_state <= HOLD;
                        end else begin
                            r_sclk    <= 1'b1;
                            r_rx_sr   <= {r_rx_sr[DATA_W-2:0], miso};
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (w_half_tick) begin
                        r_rx_data  <= r_rx_sr;
                        r_rx_valid <= 1'b1;
                        if (w_accept) begin
                            // Chained word: cs stays low, new MSB goes straight out.
                            r_tx_sr   <= i_tx_data;
                            r_bit_cnt <= '0;
                            r_mosi    <= i_tx_data[DATA_W-1];
                            r_state   <= SETUP;
                        end else begin
                            r_cs      <= 1'b1;
                            r_mosi    <= 1'b0;
                            r_gap_cnt <= '0;
                            r_state   <= GAP;
                        end
                    end
                end
                GAP: begin
                    // Guarantees a minimum cs-high time between frames.
                    if (r_gap_cnt == C_DIV_LAST) begin
                        r_gap_cnt <= '0;
                        r_state   <= IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign sclk       = r_sclk;
    assign cs         = r_cs;
    assign mosi       = r_mosi;
    assign o_rx_data  = r_rx_data;
    assign o_rx_valid = r_rx_valid;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_master_ctrl
// Description : Directed self-checking bench for spi_master_ctrl
//               (DATA_W=8, CLK_DIV=4) with a mode-0 slave model on miso.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master_ctrl;
    import spi_pkg::*;

    localparam int DATA_W  = SPI_DATA_W;
    localparam int CLK_DIV = SPI_CLK_DIV;

    logic              clk = 1'b0;
    logic              i_reset;
    logic [DATA_W-1:0] i_tx_data;
    logic              i_tx_valid;
    logic              o_tx_ready;
    logic [DATA_W-1:0] o_rx_data;
    logic              o_rx_valid;
    logic              sclk;
    logic              mosi;
    logic              miso;
    logic              cs;

    logic              loopback;
    logic              slave_miso;

    assign miso = loopback ? mosi : slave_miso;

    always #5 clk = ~clk;

    spi_master_ctrl #(
        .DATA_W  (DATA_W),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .i_clk      (clk),
        .i_reset    (i_reset),
        .i_tx_data  (i_tx_data),
        .i_tx_valid (i_tx_valid),
        .o_tx_ready (o_tx_ready),
        .o_rx_data  (o_rx_data),
        .o_rx_valid (o_rx_valid),
        .sclk       (sclk),
        .mosi       (mosi),
        .miso       (miso),
        .cs         (cs)
    );

    int          checks;
    int          failures;
    int          cyc;
    int          n_acc;
    int          want;
    logic [7:0]  words [0:1];
    logic [7:0]  slave_words [0:3];
    int          word_idx;
    int          slave_bit;
    int          cs_low;
    int          cs_falls;
    int          first_fall;
    int          first_rise;
    int          rises;
    int          last_cs_rise;
    int          min_gap;
    logic [15:0] mosi_bits;
    int          rxv_high;
    int          rxv_pulses;
    logic [7:0]  rx_words [0:3];
    int          acc_cyc [0:3];
    logic        prev_cs;
    logic        prev_sclk;
    logic        prev_rxv;
    int          busy_lo;
    int          busy_hi;
    int          busy_ready_seen;

    task automatic clear_obs();
        cyc = 0; n_acc = 0; want = 0; word_idx = 0; slave_bit = 0;
        cs_low = 0; cs_falls = 0; first_fall = -1; first_rise = -1; rises = 0;
        last_cs_rise = -1; min_gap = 1000; mosi_bits = '0;
        rxv_high = 0; rxv_pulses = 0; busy_lo = -1; busy_hi = -2; busy_ready_seen = 0;
        for (int i = 0; i < 4; i++) begin
            rx_words[i] = '0; acc_cyc[i] = -1; slave_words[i] = '0;
        end
        prev_cs = cs; prev_sclk = sclk; prev_rxv = o_rx_valid;
        loopback = 1'b0; slave_miso = 1'b0;
    endtask

    // Observe DUT at each falling clk edge, model the slave, then drive inputs.
    task automatic watch(input int n, input int stop_rises);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            cyc++;
            if (cs === 1'b0) cs_low++;
            if (cs === 1'b0 && prev_cs === 1'b1) begin
                cs_falls++;
                if (first_fall < 0) first_fall = cyc;
                if (last_cs_rise >= 0 && (cyc - last_cs_rise) < min_gap) min_gap = cyc - last_cs_rise;
                slave_bit  = 0;
                slave_miso = slave_words[word_idx][7];
            end
            if (cs === 1'b1 && prev_cs === 1'b0) last_cs_rise = cyc;
            if (sclk === 1'b1 && prev_sclk === 1'b0) begin
                rises++;
                if (first_rise < 0) first_rise = cyc;
                mosi_bits = {mosi_bits[14:0], mosi};
            end
            if (sclk === 1'b0 && prev_sclk === 1'b1 && cs === 1'b0) begin
                slave_bit++;
                if (slave_bit == DATA_W) begin
                    slave_bit = 0;
                    if (word_idx < 3) word_idx++;
                end
                slave_miso = slave_words[word_idx][7 - slave_bit];
            end
            if (o_rx_valid === 1'b1) begin
                rxv_high++;
                if (prev_rxv !== 1'b1) begin
                    if (rxv_pulses < 4) rx_words[rxv_pulses] = o_rx_data;
                    rxv_pulses++;
                end
            end
            if (cyc >= busy_lo && cyc <= busy_hi && o_tx_ready !== 1'b0) busy_ready_seen++;
            prev_cs = cs; prev_sclk = sclk; prev_rxv = o_rx_valid;
            if (cyc >= busy_lo && cyc <= busy_hi) begin
                i_tx_valid = 1'b1; i_tx_data = 8'h77;
            end else if (n_acc < want) begin
                i_tx_valid = 1'b1; i_tx_data = words[n_acc];
            end else begin
                i_tx_valid = 1'b0;
            end
            if (i_tx_valid && o_tx_ready === 1'b1) begin
                if (n_acc < 4) acc_cyc[n_acc] = cyc;
                n_acc++;
            end
            if (stop_rises > 0 && rises >= stop_rises) break;
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_tx_valid = 1'b0; i_tx_data = '0;
        loopback = 1'b0; slave_miso = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (cs !== 1'b1) begin failures++; $display("FAIL reset_cs got=%b exp=1", cs); end
        checks++; if (sclk !== 1'b0) begin failures++; $display("FAIL reset_sclk got=%b exp=0", sclk); end
        checks++; if (mosi !== 1'b0) begin failures++; $display("FAIL reset_mosi got=%b exp=0", mosi); end
        checks++; if (o_rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data got=%h exp=00", o_rx_data); end
        checks++; if (o_rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%b exp=0", o_rx_valid); end
        i_reset = 1'b0;
        @(negedge clk);
        checks++; if (o_tx_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", o_tx_ready); end
    endtask

    task automatic test_single();
        clear_obs();
        words[0] = 8'hA5; slave_words[0] = 8'h3C; want = 1;
        watch(100, 0);
        checks++; if (n_acc !== 1) begin failures++; $display("FAIL single_accepts got=%0d exp=1", n_acc); end
        checks++; if (mosi_bits[7:0] !== 8'hA5) begin failures++; $display("FAIL single_mosi got=%h exp=a5", mosi_bits[7:0]); end
        checks++; if (rises !== 8) begin failures++; $display("FAIL single_rises got=%0d exp=8", rises); end
        checks++; if (cs_low !== 72) begin failures++; $display("FAIL single_cs_low got=%0d exp=72", cs_low); end
        checks++; if (rxv_pulses !== 1 || rxv_high !== 1) begin failures++; $display("FAIL single_rx_valid pulses=%0d high=%0d exp=1/1", rxv_pulses, rxv_high); end
        checks++; if (rx_words[0] !== 8'h3C) begin failures++; $display("FAIL single_rx_data got=%h exp=3c", rx_words[0]); end
        checks++; if (o_tx_ready !== 1'b1) begin failures++; $display("FAIL single_ready_end got=%b exp=1", o_tx_ready); end
    endtask

    task automatic test_loopback();
        clear_obs();
        loopback = 1'b1; words[0] = 8'h5A; want = 1;
        watch(100, 0);
        checks++; if (rx_words[0] !== 8'h5A || rxv_pulses !== 1) begin failures++; $display("FAIL loop_rx_data got=%h pulses=%0d exp=5a/1", rx_words[0], rxv_pulses); end
        checks++; if (first_rise - first_fall !== 4) begin failures++; $display("FAIL loop_first_rise got=%0d exp=4", first_rise - first_fall); end
        checks++; if (first_fall - acc_cyc[0] !== 1) begin failures++; $display("FAIL loop_cs_fall got=%0d exp=1", first_fall - acc_cyc[0]); end
        loopback = 1'b0;
    endtask

`ifndef SPI_MASTER_CTRL_BURST_EN
    task automatic test_back_to_back();
        clear_obs();
        words[0] = 8'h01; words[1] = 8'hFF; want = 2;
        slave_words[0] = 8'h96; slave_words[1] = 8'h69;
        watch(200, 0);
        checks++; if (n_acc !== 2 || acc_cyc[1] - acc_cyc[0] !== 77) begin failures++; $display("FAIL b2b_accept_gap got=%0d n=%0d exp=77/2", acc_cyc[1] - acc_cyc[0], n_acc); end
        checks++; if (cs_falls !== 2) begin failures++; $display("FAIL b2b_frames got=%0d exp=2", cs_falls); end
        checks++; if (min_gap < 4) begin failures++; $display("FAIL b2b_cs_high got=%0d exp>=4", min_gap); end
        checks++; if (cs_low !== 144) begin failures++; $display("FAIL b2b_cs_low got=%0d exp=144", cs_low); end
        checks++; if (mosi_bits !== 16'h01FF) begin failures++; $display("FAIL b2b_mosi got=%h exp=01ff", mosi_bits); end
        checks++; if (rxv_pulses !== 2 || rx_words[0] !== 8'h96 || rx_words[1] !== 8'h69) begin failures++; $display("FAIL b2b_rx got=%h,%h n=%0d exp=96,69/2", rx_words[0], rx_words[1], rxv_pulses); end
    endtask
`endif

    task automatic test_busy_ignore();
        clear_obs();
        words[0] = 8'h12; want = 1; busy_lo = 12; busy_hi = 45;
        watch(160, 0);
        checks++; if (busy_ready_seen !== 0) begin failures++; $display("FAIL busy_ready got=%0d exp=0", busy_ready_seen); end
        checks++; if (n_acc !== 1) begin failures++; $display("FAIL busy_accepts got=%0d exp=1", n_acc); end
        checks++; if (cs_falls !== 1) begin failures++; $display("FAIL busy_frames got=%0d exp=1", cs_falls); end
        checks++; if (mosi_bits[7:0] !== 8'h12 || rises !== 8) begin failures++; $display("FAIL busy_mosi got=%h rises=%0d exp=12/8", mosi_bits[7:0], rises); end
    endtask

    task automatic test_reset_mid_frame();
        clear_obs();
        words[0] = 8'hF0; slave_words[0] = 8'hAA; want = 1;
        watch(100, 3);
        checks++; if (rises !== 3) begin failures++; $display("FAIL midrst_reach got=%0d exp=3", rises); end
        i_reset = 1'b1; i_tx_valid = 1'b0;
        @(negedge clk);
        checks++; if (cs !== 1'b1 || sclk !== 1'b0) begin failures++; $display("FAIL midrst_pins cs=%b sclk=%b exp=1/0", cs, sclk); end
        checks++; if (mosi !== 1'b0) begin failures++; $display("FAIL midrst_mosi got=%b exp=0", mosi); end
        i_reset = 1'b0;
        watch(100, 0);
        checks++; if (rxv_pulses !== 0) begin failures++; $display("FAIL midrst_rx_valid got=%0d exp=0", rxv_pulses); end
        checks++; if (o_tx_ready !== 1'b1 || cs_falls !== 1) begin failures++; $display("FAIL midrst_idle ready=%b frames=%0d exp=1/1", o_tx_ready, cs_falls); end
    endtask

`ifdef SPI_MASTER_CTRL_BURST_EN
    task automatic test_burst();
        clear_obs();
        words[0] = 8'hC3; words[1] = 8'h3C; want = 2;
        slave_words[0] = 8'h81; slave_words[1] = 8'h7E;
        watch(250, 0);
        checks++; if (cs_falls !== 1) begin failures++; $display("FAIL burst_frames got=%0d exp=1", cs_falls); end
        checks++; if (cs_low !== 144) begin failures++; $display("FAIL burst_cs_low got=%0d exp=144", cs_low); end
        checks++; if (n_acc !== 2 || acc_cyc[1] - acc_cyc[0] !== 72) begin failures++; $display("FAIL burst_accept got=%0d n=%0d exp=72/2", acc_cyc[1] - acc_cyc[0], n_acc); end
        checks++; if (mosi_bits !== 16'hC33C) begin failures++; $display("FAIL burst_mosi got=%h exp=c33c", mosi_bits); end
        checks++; if (rxv_pulses !== 2 || rx_words[0] !== 8'h81 || rx_words[1] !== 8'h7E) begin failures++; $display("FAIL burst_rx got=%h,%h n=%0d exp=81,7e/2", rx_words[0], rx_words[1], rxv_pulses); end
    endtask
`endif

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_single();
        test_loopback();
`ifndef SPI_MASTER_CTRL_BURST_EN
        test_back_to_back();
`endif
        test_busy_ignore();
        test_reset_mid_frame();
`ifdef SPI_MASTER_CTRL_BURST_EN
        test_burst();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
